// File: rtl/sdram_arbiter.sv
// Three-port (video/cpu/dma) slot arbiter in front of an 8-phase SDRAM controller.
// Grants are decided one slot ahead at ph6, acked at ph7 of the slot they ran in.
module sdram_arbiter #(
  parameter int REFRESH_MAX = 16
) (
  input  logic        clk_64,
  input  logic        reset,
  input  logic        clk_8,

  input  logic        vid_req,
  input  logic [23:0] vid_addr,
  output logic        vid_ack,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [23:0] cpu_addr,
  input  logic [1:0]  cpu_ds,
  input  logic [15:0] cpu_din,
  output logic        cpu_ack,

  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [23:0] dma_addr,
  input  logic [1:0]  dma_ds,
  input  logic [15:0] dma_din,
  output logic        dma_ack,

  output logic [15:0] rdata,

  output logic        sd_oe,
  output logic        sd_we,
  output logic [23:0] sd_addr,
  output logic [1:0]  sd_ds,
  output logic [15:0] sd_din,
  input  logic [15:0] sd_dout
);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_VID  = 2'd1;
  localparam logic [1:0] SRC_CPU  = 2'd2;
  localparam logic [1:0] SRC_DMA  = 2'd3;

  logic [2:0] ph;
  logic [7:0] rc;
  logic [1:0] pend_src;  // grant already on sd_*, slot not yet finished
  logic       pend_rd;
  logic [1:0] act_src;   // slot finishing now, waiting for its ph7 ack
  logic       act_rd;

  logic       ph_adv;
  logic       force_idle;
  logic [1:0] pick;

  // ph parks at 7 while clk_8 is high and at 0 while it is low, which
  // locks the round to the controller's own clk_8-driven slot counter.
  always_comb begin
    ph_adv = ((ph == 3'd7) && !clk_8) ||
             ((ph == 3'd0) &&  clk_8) ||
             ((ph != 3'd0) && (ph != 3'd7));
  end

  // The port holding the pending slot is skipped: its req stays high until
  // that slot's ack, which arrives only after this decision.
  always_comb begin
    force_idle = (rc == 8'(REFRESH_MAX - 1));
    pick       = SRC_NONE;
    if (!force_idle) begin
      if (vid_req && (pend_src != SRC_VID))      pick = SRC_VID;
      else if (cpu_req && (pend_src != SRC_CPU)) pick = SRC_CPU;
      else if (dma_req && (pend_src != SRC_DMA)) pick = SRC_DMA;
    end
  end

  always_ff @(posedge clk_64) begin
    if (reset) begin
      ph       <= 3'd0;
      rc       <= 8'd0;
      pend_src <= SRC_NONE;
      pend_rd  <= 1'b0;
      act_src  <= SRC_NONE;
      act_rd   <= 1'b0;
      sd_oe    <= 1'b0;
      sd_we    <= 1'b0;
      sd_addr  <= 24'd0;
      sd_ds    <= 2'd0;
      sd_din   <= 16'd0;
      rdata    <= 16'd0;
      vid_ack  <= 1'b0;
      cpu_ack  <= 1'b0;
      dma_ack  <= 1'b0;
    end else begin
      vid_ack <= 1'b0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      if (ph_adv) ph <= ph + 3'd1;

      if (ph == 3'd6) begin
        act_src  <= pend_src;
        act_rd   <= pend_rd;
        pend_src <= pick;
        rc       <= (pick == SRC_NONE) ? 8'd0 : rc + 8'd1;
        case (pick)
          SRC_VID: begin
            sd_oe   <= 1'b1;
            sd_we   <= 1'b0;
            sd_addr <= vid_addr;
            sd_ds   <= 2'b11;
            pend_rd <= 1'b1;
          end
          SRC_CPU: begin
            sd_oe   <= !cpu_we;
            sd_we   <= cpu_we;
            sd_addr <= cpu_addr;
            sd_ds   <= cpu_ds;
            if (cpu_we) sd_din <= cpu_din;
            pend_rd <= !cpu_we;
          end
          SRC_DMA: begin
            sd_oe   <= !dma_we;
            sd_we   <= dma_we;
            sd_addr <= dma_addr;
            sd_ds   <= dma_ds;
            if (dma_we) sd_din <= dma_din;
            pend_rd <= !dma_we;
          end
          default: begin
            // idle slot: controller refreshes, address/data lines keep last value
            sd_oe   <= 1'b0;
            sd_we   <= 1'b0;
            pend_rd <= 1'b0;
          end
        endcase
      end

      // act_src is cleared so a stretched ph7 still gives a single pulse
      if ((ph == 3'd7) && (act_src != SRC_NONE)) begin
        vid_ack <= (act_src == SRC_VID);
        cpu_ack <= (act_src == SRC_CPU);
        dma_ack <= (act_src == SRC_DMA);
        if (act_rd) rdata <= sd_dout;
        act_src <= SRC_NONE;
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Bench for sdram_arbiter: directed scenarios plus random traffic, every cycle
// compared against a slot-level reference model built from grant history.
module tb_sdram_arbiter;
  localparam int RMAX = 16;

  logic        clk_64 = 1'b0;
  logic        reset = 1'b1;
  logic        clk_8 = 1'b0;
  logic        vid_req = 1'b0;
  logic [23:0] vid_addr = '0;
  logic        vid_ack;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [23:0] cpu_addr = '0;
  logic [1:0]  cpu_ds = '0;
  logic [15:0] cpu_din = '0;
  logic        cpu_ack;
  logic        dma_req = 1'b0, dma_we = 1'b0;
  logic [23:0] dma_addr = '0;
  logic [1:0]  dma_ds = '0;
  logic [15:0] dma_din = '0;
  logic        dma_ack;
  logic [15:0] rdata;
  logic        sd_oe, sd_we;
  logic [23:0] sd_addr;
  logic [1:0]  sd_ds;
  logic [15:0] sd_din;
  logic [15:0] sd_dout = '0;

  always #5 clk_64 = ~clk_64;

  sdram_arbiter #(.REFRESH_MAX(RMAX)) dut (
    .clk_64(clk_64), .reset(reset), .clk_8(clk_8),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ds(cpu_ds),
    .cpu_din(cpu_din), .cpu_ack(cpu_ack),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_ds(dma_ds),
    .dma_din(dma_din), .dma_ack(dma_ack),
    .rdata(rdata), .sd_oe(sd_oe), .sd_we(sd_we), .sd_addr(sd_addr),
    .sd_ds(sd_ds), .sd_din(sd_din), .sd_dout(sd_dout)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // reference model: src 0 idle, 1 video, 2 cpu, 3 dma
  typedef struct { int src; bit rd; } slot_t;
  int          m_ph = 0;
  int          hist[$];
  slot_t       m_pend = '{0, 0};
  slot_t       m_act = '{0, 0};
  logic        m_oe = 0, m_we = 0;
  logic [23:0] m_addr = '0;
  logic [1:0]  m_ds = '0;
  logic [15:0] m_din = '0, m_rdata = '0;
  logic [2:0]  m_ack = '0;
  int          m_gnt_ev = -1;

  int c8 = 0, c8_off = 0, cyc = 0;
  bit auto_on = 0, rand_dout = 0;
  bit keep [3] = '{0, 0, 0};
  int n_ack [3] = '{0, 0, 0};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int run_len();
    int n = 0;
    for (int i = hist.size() - 1; i >= 0; i--) begin
      if (hist[i] == 0) break;
      n++;
    end
    return n;
  endfunction

  task automatic new_op(input int p);
    case (p)
      0: vid_addr = 24'($urandom);
      1: begin
        cpu_we = 1'($urandom); cpu_addr = 24'($urandom);
        cpu_ds = 2'($urandom_range(3, 1)); cpu_din = 16'($urandom);
      end
      default: begin
        dma_we = 1'($urandom); dma_addr = 24'($urandom);
        dma_ds = 2'($urandom_range(3, 1)); dma_din = 16'($urandom);
      end
    endcase
  endtask

  task automatic set_req(input int p, input logic v);
    case (p)
      0: vid_req = v;
      1: cpu_req = v;
      default: dma_req = v;
    endcase
  endtask

  task automatic tick();
    logic r, c8s, cw, dw;
    logic [2:0] rq;
    logic [23:0] va, ca, da;
    logic [1:0] cds, dds;
    logic [15:0] cdin, ddin, dv;
    int g;
    r = reset; c8s = clk_8; rq = {dma_req, cpu_req, vid_req};
    va = vid_addr; cw = cpu_we; ca = cpu_addr; cds = cpu_ds; cdin = cpu_din;
    dw = dma_we; da = dma_addr; dds = dma_ds; ddin = dma_din; dv = sd_dout;
    @(posedge clk_64); #1;
    cyc++;
    m_ack = '0; m_gnt_ev = -1;
    if (r) begin
      m_ph = 0; hist.delete(); m_pend = '{0, 0}; m_act = '{0, 0};
      m_oe = 0; m_we = 0; m_addr = '0; m_ds = '0; m_din = '0; m_rdata = '0;
    end else begin
      if (m_ph == 6) begin
        m_act = m_pend;
        if (run_len() == RMAX - 1) g = 0;
        else if (rq[0] && m_pend.src != 1) g = 1;
        else if (rq[1] && m_pend.src != 2) g = 2;
        else if (rq[2] && m_pend.src != 3) g = 3;
        else g = 0;
        hist.push_back(g);
        if (hist.size() > 2 * RMAX + 4) void'(hist.pop_front());
        m_gnt_ev = g;
        case (g)
          1: begin m_oe = 1; m_we = 0; m_addr = va; m_ds = 2'b11; end
          2: begin m_oe = !cw; m_we = cw; m_addr = ca; m_ds = cds; if (cw) m_din = cdin; end
          3: begin m_oe = !dw; m_we = dw; m_addr = da; m_ds = dds; if (dw) m_din = ddin; end
          default: begin m_oe = 0; m_we = 0; end
        endcase
        m_pend.src = g;
        m_pend.rd = (g == 1) || (g == 2 && !cw) || (g == 3 && !dw);
      end else if (m_ph == 7 && m_act.src != 0) begin
        m_ack[m_act.src - 1] = 1'b1;
        if (m_act.rd) m_rdata = dv;
        m_act.src = 0;
      end
      if ((m_ph == 7 && !c8s) || (m_ph == 0 && c8s) || (m_ph >= 1 && m_ph <= 6))
        m_ph = (m_ph + 1) % 8;
    end
    chk("cycle", {dma_ack, cpu_ack, vid_ack, sd_oe, sd_we, sd_addr, sd_ds, sd_din, rdata},
                 {m_ack, m_oe, m_we, m_addr, m_ds, m_din, m_rdata});
    chk("ack_onehot0", 64'($onehot0({dma_ack, cpu_ack, vid_ack})), 64'd1);
    if (vid_ack) n_ack[0]++;
    if (cpu_ack) n_ack[1]++;
    if (dma_ack) n_ack[2]++;
    c8++;
    clk_8 = (((c8 + c8_off) % 8) < 4);
    if (rand_dout) sd_dout = 16'($urandom);
    for (int p = 0; p < 3; p++) begin
      if (m_ack[p]) begin
        if (!keep[p]) set_req(p, 1'b0);
        else if (auto_on) new_op(p);
      end else if (auto_on && !rq[p] && $urandom_range(99) < 30) begin
        new_op(p);
        set_req(p, 1'b1);
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && (vid_req || cpu_req || dma_req); i++) tick();
    chk(tag, {vid_req, cpu_req, dma_req}, 3'b000);
  endtask

  initial begin
    bit got;
    int last_t, idles, ack_before;

    repeat (4) tick();
    chk("rst_sd", {sd_oe, sd_we, sd_addr, sd_ds, sd_din}, '0);
    chk("rst_rdata_ack", {rdata, vid_ack, cpu_ack, dma_ack}, '0);
    reset = 1'b0;

    // cpu read of 0x001234 returning 0xBEEF
    cpu_we = 0; cpu_addr = 24'h001234; cpu_ds = 2'b11; cpu_req = 1; sd_dout = 16'hBEEF;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (m_gnt_ev == 2) begin
        chk("r028_oe_we", {sd_oe, sd_we}, 2'b10);
        chk("r028_addr", sd_addr, 24'h001234);
      end
      if (cpu_ack) got = 1;
    end
    chk("r028_ack", got, 1);
    chk("r028_rdata", rdata, 16'hBEEF);

    // dma write 0xA5A5 to 0x3FFFFF, low byte only
    dma_we = 1; dma_addr = 24'h3FFFFF; dma_ds = 2'b01; dma_din = 16'hA5A5; dma_req = 1;
    sd_dout = 16'h1111;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (m_gnt_ev == 3) begin
        chk("r030_oe_we", {sd_oe, sd_we}, 2'b01);
        chk("r030_bus", {sd_addr, sd_ds, sd_din}, {24'h3FFFFF, 2'b01, 16'hA5A5});
      end
      if (dma_ack) got = 1;
    end
    chk("r030_ack", got, 1);
    chk("r030_rdata_kept", rdata, 16'hBEEF);

    // lone cpu requester held high: one grant every second slot
    rand_dout = 1; keep[1] = 1;
    cpu_we = 0; cpu_addr = 24'h000100; cpu_ds = 2'b10; cpu_req = 1;
    last_t = -1;
    repeat (200) begin
      tick();
      if (cpu_ack) begin
        if (last_t >= 0) chk("r031_gap", cyc - last_t, 16);
        last_t = cyc;
      end
    end
    keep[1] = 0;
    drain("r031_drain", 40);

    // all three held: video/cpu alternate, dma starved, periodic forced idle
    keep = '{1, 1, 1};
    vid_addr = 24'h00F000; cpu_we = 0; cpu_addr = 24'h000200; cpu_ds = 2'b11;
    dma_we = 1; dma_addr = 24'h000300; dma_ds = 2'b11; dma_din = 16'h5A5A;
    vid_req = 1; cpu_req = 1; dma_req = 1;
    n_ack = '{0, 0, 0}; idles = 0;
    repeat (48 * 8) begin
      tick();
      if (m_gnt_ev >= 0 && !sd_oe && !sd_we) idles++;
    end
    chk("r029_dma_starved", n_ack[2], 0);
    chk("r029_idle_2_3", (idles >= 2 && idles <= 3), 1);
    chk("r029_vid_ge_cpu", (n_ack[0] >= n_ack[1] && n_ack[1] > 16), 1);
    keep = '{0, 0, 0};
    drain("r029_drain", 120);

    // reset in the middle of a granted cpu read
    cpu_we = 0; cpu_addr = 24'h00ABCD; cpu_ds = 2'b11; cpu_req = 1;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (m_pend.src == 2 && m_ph == 3) got = 1;
    end
    chk("r032_reach_ph3", got, 1);
    ack_before = n_ack[1];
    reset = 1;
    repeat (3) tick();
    chk("r032_rst_out", {vid_ack, cpu_ack, dma_ack, sd_oe, sd_we, sd_addr, sd_ds, sd_din, rdata}, '0);
    reset = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (m_gnt_ev >= 0) got = 1;
    end
    chk("r032_no_abandoned_ack", n_ack[1] - ack_before, 0);
    chk("r032_first_grant", {sd_oe, sd_we, sd_addr}, {2'b10, 24'h00ABCD});
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (cpu_ack) got = 1;
    end
    chk("r032_ack", got, 1);

    // random traffic across clk_8 phase jumps
    auto_on = 1;
    repeat (300) tick();
    c8_off += 4;
    repeat (300) tick();
    c8_off += 3;
    repeat (300) tick();
    auto_on = 0;
    drain("r033_drain", 120);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
